alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//  32-bit integer ALU with registered outputs, for the datapath execute stage.
//  - ALU_operation uses the classic 4-bit ALU-control encoding: AND/OR/ADD/SUB,
//    plus SLT, NOR, XOR, shifts and SLTU.
//  - One clock edge of latency. Drives a zero flag for branch resolution and
//    carry/overflow flags for the status logic.
// PARAMETERS
//  WIDTH   32   datapath width; shift amount = B[$clog2(WIDTH)-1:0]
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  A              in   WIDTH  operand A
//  B              in   WIDTH  operand B
//  ALU_operation  in   4      operation select (table below)
//  ALU_result     out  WIDTH  registered result
//  zero           out  1      registered; 1 when ALU_result == 0
//  carry          out  1      registered carry-out (ADD/SUB only, else 0)
//  overflow       out  1      registered signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//  - Clocking and reset
//    - Single clk domain.
//    - rst is synchronous and active-high.
//    - While rst=1 at a rising edge: ALU_result=0, zero=1, carry=0, overflow=0.
//    - rst has priority over any operation.
//  - Latency and handshake
//    - A, B and ALU_operation are sampled every rising edge. There is no handshake.
//    - Outputs update on that same edge and hold until the next edge (latency 1).
//    - Inputs that change between edges have no effect on the outputs.
//  - Operation encoding (result computed combinationally, then registered):
//    - 0000 AND   A & B
//    - 0001 OR    A | B
//    - 0010 ADD   A + B, mod 2^WIDTH
//    - 0110 SUB   A - B, computed as A + ~B + 1, mod 2^WIDTH
//    - 0111 SLT   {0..,1} if $signed(A) < $signed(B), else 0
//    - 1001 SLTU  {0..,1} if A < B unsigned, else 0
//    - 1100 NOR   ~(A | B)
//    - 0011 XOR   A ^ B
//    - 0100 SLL   A << B[4:0]
//    - 0101 SRL   A >> B[4:0], logical (zero fill)
//    - 1000 SRA   $signed(A) >>> B[4:0], sign fill
//    - Any other code: result 0, carry 0, overflow 0. zero then reads 1.
//  - Flags
//    - zero is derived from the result being registered, in the same cycle as
//      ALU_result, for every operation.
//    - ADD carry = bit WIDTH of the (WIDTH+1)-bit sum.
//    - SUB carry = carry-out of A + ~B + 1, so carry=1 means no borrow (A >= B unsigned).
//    - overflow, ADD: operands have the same sign and the result sign differs.
//    - overflow, SUB: operands have different signs and the result sign differs from A.
//  - Boundary conditions
//    - A == B under SUB gives result 0, zero=1, carry=1, overflow=0.
//    - Shift amount uses only B[4:0]. B=32 shifts by 0.
//    - 0x7FFFFFFF + 1 gives 0x80000000, overflow=1, carry=0.
//    - 0x80000000 - 1 gives 0x7FFFFFFF, overflow=1.
//    - Wrap-around: 0xFFFFFFFF + 1 gives 0, zero=1, carry=1, overflow=0.
//    - If reset is asserted mid-stream, the next edge outputs the reset values
//      regardless of inputs. Normal operation resumes on the first edge with rst=0.
// TESTING
//  1. rst=1 for 2 edges with A=45, B=67, op=0010 -> ALU_result=0, zero=1, carry=0,
//     overflow=0. Release rst; after the next edge ALU_result=112.
//  2. A=45, B=67, ops 0000/0001/0010/0110 on successive edges -> results 1, 111,
//     112, 0xFFFFFFEA (SUB: carry=0, zero=0). Each result appears one edge after
//     its inputs.
//  3. A=B=33, op=0110 -> result 0, zero=1, carry=1.
//     Then A=67, B=45, op=0110 -> result 22, zero=0, carry=1.
//  4. A=0xFFFFFFEA (-22), B=5: op 0111 -> 1; op 1001 -> 0; op 1000 with B=2 -> 0xFFFFFFFA.
//  5. Overflow and wrap-around:
//     - 0x7FFFFFFF + 1 -> 0x80000000, overflow=1.
//     - 0xFFFFFFFF + 1 -> 0, zero=1, carry=1.
//     - op=1111 -> result 0, zero=1.
//  6. Shifts with A=0x80000001: SLL B=4 -> 0x00000010; SRL B=1 -> 0x40000000;
//     SRL B=32 -> 0x80000001. Assert rst mid-sequence -> next edge outputs the reset values.

Source files
------------

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purpose : integer ALU for the datapath execute stage. The result and all
//           flags are computed combinationally from the operands sampled on a
//           rising clock edge and are registered on that same edge
//           (latency of one edge, no handshake).
// Ports   :
//   clk            in   1      single clock, rising edge
//   rst            in   1      synchronous, active-high reset
//   A              in   WIDTH  operand A
//   B              in   WIDTH  operand B (shift amount = B[$clog2(WIDTH)-1:0])
//   ALU_operation  in   4      operation select
//   ALU_result     out  WIDTH  registered result
//   zero           out  1      registered, 1 when ALU_result == 0
//   carry          out  1      registered carry-out, ADD/SUB only
//   overflow       out  1      registered signed overflow, ADD/SUB only
// ---------------------------------------------------------------------------
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;

  // Signed overflow of a two's-complement addition a + b_eff (+cin):
  // both addends share a sign and the sum's sign differs from it.
  function automatic logic add_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
    add_overflow = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Zero-extend a single compare bit to a full result word.
  function automatic logic [WIDTH-1:0] bit_to_word(input logic b);
    bit_to_word = {{(WIDTH-1){1'b0}}, b};
  endfunction

  logic             is_sub_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_ext_s;
  logic             add_ovf_s;
  logic [SHW-1:0]   shamt_s;
  logic             slt_s;
  logic             sltu_s;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d,   zero_q;
  logic             carry_d,  carry_q;
  logic             overflow_d, overflow_q;

  // Shared adder: SUB reuses the ADD path as A + ~B + 1 so that its carry-out
  // directly means "no borrow" (A >= B unsigned).
  always_comb begin
    is_sub_s = 1'b0;
    b_eff_s  = B;
    if (ALU_operation == OP_SUB) begin
      is_sub_s = 1'b1;
      b_eff_s  = ~B;
    end else begin
      is_sub_s = 1'b0;
      b_eff_s  = B;
    end
    sum_ext_s = {1'b0, A} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, is_sub_s};
    add_ovf_s = add_overflow(A[WIDTH-1], b_eff_s[WIDTH-1], sum_ext_s[WIDTH-1]);
  end

  // Compare and shift-amount helpers, independent of the adder.
  always_comb begin
    shamt_s = B[SHW-1:0];
    slt_s   = ($signed(A) < $signed(B));
    sltu_s  = (A < B);
  end

  // Operation select; flags other than zero are only meaningful for ADD/SUB.
  always_comb begin
    result_d   = {WIDTH{1'b0}};
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (ALU_operation)
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_ADD, OP_SUB: begin
        result_d   = sum_ext_s[WIDTH-1:0];
        carry_d    = sum_ext_s[WIDTH];
        overflow_d = add_ovf_s;
      end
      OP_XOR:  result_d = A ^ B;
      OP_SLL:  result_d = A << shamt_s;
      OP_SRL:  result_d = A >> shamt_s;
      OP_SLT:  result_d = bit_to_word(slt_s);
      OP_SRA:  result_d = $unsigned($signed(A) >>> shamt_s);
      OP_SLTU: result_d = bit_to_word(sltu_s);
      OP_NOR:  result_d = ~(A | B);
      default: begin
        result_d   = {WIDTH{1'b0}};
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
    // zero follows the value actually being registered, for every op.
    zero_d = (result_d == {WIDTH{1'b0}});
  end

  // Output register; reset wins over any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= {WIDTH{1'b0}};
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign ALU_result = result_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core
// Purpose : self-checking bench for alu_core. A behavioural model, written
//           with plain 64-bit arithmetic, predicts the outputs from the inputs
//           seen at each rising edge; a compare process checks the DUT against
//           it on every falling edge. Directed vectors additionally pin the
//           outputs to hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [3:0]  op_s;
  logic [31:0] res_s;
  logic        zero_s;
  logic        carry_s;
  logic        ovf_s;

  int total;
  int bad;

  logic [31:0] exp_res;
  logic        exp_zero;
  logic        exp_carry;
  logic        exp_ovf;
  logic        exp_valid;

  alu_core #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .A             (a_s),
    .B             (b_s),
    .ALU_operation (op_s),
    .ALU_result    (res_s),
    .zero          (zero_s),
    .carry         (carry_s),
    .overflow      (ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what each operation means arithmetically.
  function automatic void model(input logic r, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] op,
                                output logic [31:0] res, output logic z,
                                output logic c, output logic o);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned full;
    longint          sa;
    longint          sb;
    longint          so;
    int              amt;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = int'(b % 32'd32);
    res = 32'd0;
    c   = 1'b0;
    o   = 1'b0;
    if (r) begin
      res = 32'd0;
    end else begin
      case (op)
        4'b0000: res = a & b;
        4'b0001: res = a | b;
        4'b0010: begin
          full = ua + ub;
          res  = full[31:0];
          c    = full[32];
          so   = sa + sb;
          o    = (so > 64'sd2147483647) || (so < -64'sd2147483648);
        end
        4'b0110: begin
          full = ua - ub;
          res  = full[31:0];
          c    = (ua >= ub);
          so   = sa - sb;
          o    = (so > 64'sd2147483647) || (so < -64'sd2147483648);
        end
        4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
        4'b1001: res = (ua < ub) ? 32'd1 : 32'd0;
        4'b1100: res = ~(a | b);
        4'b0011: res = a ^ b;
        4'b0100: begin
          full = ua * (64'd1 << amt);
          res  = full[31:0];
        end
        4'b0101: res = 32'(ua / (64'd1 << amt));
        4'b1000: begin
          so  = sa >>> amt;
          res = so[31:0];
        end
        default: res = 32'd0;
      endcase
    end
    z = (res == 32'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] er,
                       input logic ez, input logic ec, input logic eo);
    total++;
    if (res_s !== er || zero_s !== ez || carry_s !== ec || ovf_s !== eo) begin
      bad++;
      $display("FAIL %s: got res=%h z=%b c=%b o=%b, want res=%h z=%b c=%b o=%b",
               name, res_s, zero_s, carry_s, ovf_s, er, ez, ec, eo);
    end
  endtask

  // Model prediction from the inputs present at each rising edge.
  always @(posedge clk) begin
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        o;
    model(rst, a_s, b_s, op_s, r, z, c, o);
    exp_res   <= r;
    exp_zero  <= z;
    exp_carry <= c;
    exp_ovf   <= o;
    exp_valid <= 1'b1;
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (exp_valid === 1'b1) begin
      check("model", exp_res, exp_zero, exp_carry, exp_ovf);
    end
  end

  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    rst  = r;
    a_s  = a;
    b_s  = b;
    op_s = op;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000ns");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    exp_valid = 1'b0;
    rst  = 1'b1;
    a_s  = 32'd45;
    b_s  = 32'd67;
    op_s = 4'b0010;

    // 1. reset for two edges, then release
    apply(1'b1, 32'd45, 32'd67, 4'b0010);
    check("rst1", 32'd0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 32'd45, 32'd67, 4'b0010);
    check("rst2", 32'd0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 32'd45, 32'd67, 4'b0010);
    check("add_release", 32'd112, 1'b0, 1'b0, 1'b0);

    // 2. basic ops
    apply(1'b0, 32'd45, 32'd67, 4'b0000);
    check("and", 32'd1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'd45, 32'd67, 4'b0001);
    check("or", 32'd111, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'd45, 32'd67, 4'b0010);
    check("add", 32'd112, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'd45, 32'd67, 4'b0110);
    check("sub_neg", 32'hFFFF_FFEA, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'd45, 32'd67, 4'b0011);
    check("xor", 32'd110, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'd45, 32'd67, 4'b1100);
    check("nor", 32'hFFFF_FF90, 1'b0, 1'b0, 1'b0);

    // 3. SUB equal and positive
    apply(1'b0, 32'd33, 32'd33, 4'b0110);
    check("sub_eq", 32'd0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 32'd67, 32'd45, 4'b0110);
    check("sub_pos", 32'd22, 1'b0, 1'b1, 1'b0);

    // 4. compares and arithmetic shift on a negative value
    apply(1'b0, 32'hFFFF_FFEA, 32'd5, 4'b0111);
    check("slt", 32'd1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'hFFFF_FFEA, 32'd5, 4'b1001);
    check("sltu", 32'd0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 32'hFFFF_FFEA, 32'd2, 4'b1000);
    check("sra", 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);

    // 5. overflow, wrap-around, unknown opcode
    apply(1'b0, 32'h7FFF_FFFF, 32'd1, 4'b0010);
    check("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    check("add_wrap", 32'd0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 32'h8000_0000, 32'd1, 4'b0110);
    check("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111);
    check("bad_op", 32'd0, 1'b1, 1'b0, 1'b0);

    // 6. logical shifts, B=32 wraps to 0, reset mid-stream
    apply(1'b0, 32'h8000_0001, 32'd4, 4'b0100);
    check("sll", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'h8000_0001, 32'd1, 4'b0101);
    check("srl", 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'h8000_0001, 32'd1, 4'b0101);
    check("rst_mid", 32'd0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 32'h8000_0001, 32'd32, 4'b0101);
    check("srl_32", 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 32'h8000_0001, 32'd33, 4'b1000);
    check("sra_33", 32'hC000_0000, 1'b0, 1'b0, 1'b0);

    // inputs changing between edges must not disturb held outputs
    a_s  = 32'd0;
    b_s  = 32'd0;
    op_s = 4'b0000;
    #4;
    check("hold", 32'hC000_0000, 1'b0, 1'b0, 1'b0);

    // a few extra vectors judged only by the model
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 32'hDEAD_BEEF ^ (32'h0101_0101 * 32'(i)),
            32'h0F0F_1234 + 32'(i * 7), 4'(i));
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
